// File: rtl/timer_if.sv
// Avalon-MM connection to the interval timer's 16-bit s1 slave port.
// The scheduler drives it as master; the timer (or its model) is the slave.
interface timer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/timer_tick_scheduler.sv
// Services interval-timer timeouts over Avalon-MM and turns each one into a
// global tick, fanned out to NUM_CH divided channels with pending/overrun flags.
module timer_tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  timer_if.master           tmr,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] ch_pending,
  output logic [NUM_CH-1:0] ch_overrun,
  output logic [TICK_W-1:0] tick_count,
  output logic              running
);

  typedef enum logic [2:0] {
    S_INIT, S_ARM, S_IDLE, S_RD, S_CHK, S_CLR, S_SETTLE, S_DISPATCH
  } state_t;

  state_t state_q, state_d;

  logic        cs_q, cs_d;
  logic        wr_n_q, wr_n_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        running_q, running_d;
  logic        tick_valid_q, tick_valid_d;
  logic [TICK_W-1:0] tick_q, tick_d;

  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [DIV_W-1:0] div_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q [NUM_CH];
  logic [DIV_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;

  logic [NUM_CH-1:0] cfg_hit;
  logic [NUM_CH-1:0] due;
  logic              dispatch;

  // Only bit 0 (TO) of the status register carries information here.
  logic unused_rd_bits;
  assign unused_rd_bits = ^tmr.readdata[15:1];

  assign dispatch = (state_q == S_DISPATCH);

  // Bus registers are loaded with the access of the state being entered, so
  // each access is on the bus during its own state; readdata then lands in CHK.
  always_comb begin
    state_d      = state_q;
    cs_d         = 1'b0;
    wr_n_d       = 1'b1;
    addr_d       = 3'd0;
    wdata_d      = 16'h0000;
    running_d    = running_q;
    tick_valid_d = tick_valid_q;
    tick_d       = tick_q;
    case (state_q)
      S_INIT: begin
        cs_d    = 1'b1;
        wr_n_d  = 1'b0;
        addr_d  = 3'd1;
        wdata_d = 16'h0001;
        state_d = S_ARM;
      end
      S_ARM: begin
        running_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_IDLE: begin
        if (tmr.irq) begin
          cs_d    = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_CHK;
      S_CHK: begin
        tick_valid_d = tmr.readdata[0];
        cs_d         = 1'b1;
        wr_n_d       = 1'b0;
        state_d      = S_CLR;
      end
      S_CLR: state_d = S_SETTLE;
      S_SETTLE: state_d = tick_valid_q ? S_DISPATCH : S_IDLE;
      S_DISPATCH: begin
        tick_d  = tick_q + TICK_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // A config write on a channel overrides that channel's dispatch update.
  always_comb begin
    cfg_hit = '0;
    due     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_hit[c] = cfg_we && (cfg_ch == 3'(c));
      due[c]     = dispatch && !cfg_hit[c] && (div_q[c] != '0) &&
                   (cnt_q[c] == div_q[c] - DIV_W'(1));
    end
  end

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_hit[c]) begin
        div_d[c] = cfg_div;
        cnt_d[c] = '0;
      end else if (dispatch && div_q[c] != '0) begin
        cnt_d[c] = due[c] ? '0 : cnt_q[c] + DIV_W'(1);
      end
      if (due[c]) begin
        pend_d[c] = 1'b1;
        if (pend_q[c] && !ch_ack[c]) ovr_d[c] = 1'b1;
        else if (ch_ack[c])          ovr_d[c] = 1'b0;
      end else if (ch_ack[c]) begin
        pend_d[c] = 1'b0;
        ovr_d[c]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_INIT;
      cs_q         <= 1'b0;
      wr_n_q       <= 1'b1;
      addr_q       <= 3'd0;
      wdata_q      <= 16'h0000;
      running_q    <= 1'b0;
      tick_valid_q <= 1'b0;
      tick_q       <= '0;
      pend_q       <= '0;
      ovr_q        <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        div_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      wr_n_q       <= wr_n_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      running_q    <= running_d;
      tick_valid_q <= tick_valid_d;
      tick_q       <= tick_d;
      pend_q       <= pend_d;
      ovr_q        <= ovr_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
    end
  end

  assign tmr.chipselect = cs_q;
  assign tmr.write_n    = wr_n_q;
  assign tmr.address    = addr_q;
  assign tmr.writedata  = wdata_q;
  assign ch_pending     = pend_q;
  assign ch_overrun     = ovr_q;
  assign tick_count     = tick_q;
  assign running        = running_q;

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Bench for timer_tick_scheduler: interval-timer model, hand-written vector
// table, randomized traffic against a tick-counting reference model.
module tb_timer_tick_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int TW  = 8;  // narrow tick counter so the wrap is reachable quickly

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [2:0]     cfg_ch = 3'd0;
  logic [DW-1:0]  cfg_div = '0;
  logic [NCH-1:0] ch_ack = '0;
  logic [NCH-1:0] ch_pending, ch_overrun;
  logic [TW-1:0]  tick_count;
  logic           running;

  timer_if tif ();

  timer_tick_scheduler #(.NUM_CH(NCH), .DIV_W(DW), .TICK_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .tmr(tif),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .ch_ack(ch_ack),
    .ch_pending(ch_pending), .ch_overrun(ch_overrun),
    .tick_count(tick_count), .running(running)
  );

  always #5 clk = ~clk;

  // Interval timer model: status TO bit, control ITO bit, registered readdata.
  logic        to_q, spur_q;
  logic [15:0] ctrl_q, rd_q;
  bit          to_req = 0, spur_req = 0;
  int          ctrl_writes = 0;

  assign tif.readdata = rd_q;
  assign tif.irq      = (to_q & ctrl_q[0]) | spur_q;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q <= 1'b0; spur_q <= 1'b0; ctrl_q <= 16'h0; rd_q <= 16'h0;
    end else begin
      rd_q <= (tif.address == 3'd0) ? {15'h0, to_q} :
              (tif.address == 3'd1) ? ctrl_q : 16'h0;
      if (tif.chipselect && !tif.write_n && tif.address == 3'd0) begin
        to_q <= 1'b0; spur_q <= 1'b0;
      end else begin
        if (to_req)   to_q   <= 1'b1;
        if (spur_req) spur_q <= 1'b1;
      end
      if (tif.chipselect && !tif.write_n && tif.address == 3'd1) ctrl_q <= tif.writedata;
    end
  end

  always @(posedge clk)
    if (reset_n && tif.chipselect && !tif.write_n && tif.address == 3'd1)
      ctrl_writes <= ctrl_writes + 1;

  // Reference model: ticks elapsed since each channel was configured.
  int       m_div [NCH];
  int       m_since [NCH];
  bit [3:0] m_pend, m_ovr;
  int       m_tick;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin m_div[c] = 0; m_since[c] = 0; end
    m_pend = '0; m_ovr = '0; m_tick = 0;
  endtask

  task automatic m_idle(input bit we, input logic [2:0] ch, input logic [7:0] d, input logic [3:0] a);
    m_pend &= ~a;
    m_ovr  &= ~a;
    if (we && int'(ch) < NCH) begin m_div[ch] = int'(d); m_since[ch] = 0; end
  endtask

  task automatic m_dispatch(input logic [3:0] a, input bit we, input logic [2:0] ch, input logic [7:0] d);
    for (int c = 0; c < NCH; c++) begin
      bit due;
      due = 0;
      if (we && int'(ch) == c) begin
        m_div[c] = int'(d); m_since[c] = 0;
      end else if (m_div[c] != 0) begin
        m_since[c]++;
        due = (m_since[c] % m_div[c]) == 0;
      end
      if (due) begin
        if (m_pend[c] && !a[c]) m_ovr[c] = 1'b1;
        else if (a[c])          m_ovr[c] = 1'b0;
        m_pend[c] = 1'b1;
      end else if (a[c]) begin
        m_pend[c] = 1'b0; m_ovr[c] = 1'b0;
      end
    end
    m_tick = (m_tick + 1) % (1 << TW);
  endtask

  task automatic apply_idle(input bit we, input logic [2:0] ch, input logic [7:0] d, input logic [3:0] a);
    cfg_we = we; cfg_ch = ch; cfg_div = d; ch_ack = a;
    @(negedge clk);
    cfg_we = 1'b0; ch_ack = '0;
    m_idle(we, ch, d, a);
  endtask

  // One timeout (b0=1) or spurious irq (b0=0); ackd/cfg are driven in the
  // cycle that would be DISPATCH.
  task automatic service(input bit b0, input logic [3:0] ackd, input bit dwe,
                         input logic [2:0] dch, input logic [7:0] ddiv);
    bit found;
    found = 0;
    if (b0) to_req = 1; else spur_req = 1;
    @(negedge clk);
    to_req = 0; spur_req = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (tif.chipselect && tif.write_n) found = 1;
      else @(negedge clk);
    end
    chk("svc_read_seen", 32'(found), 32'd1);
    if (!found) return;
    chk("svc_read_addr", 32'(tif.address), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("svc_clear_write", {11'h0, tif.chipselect, tif.write_n, tif.address, tif.writedata},
        {11'h0, 1'b1, 1'b0, 3'd0, 16'h0000});
    @(negedge clk);
    @(negedge clk);
    chk("svc_not_early", 32'(ch_pending), 32'(m_pend));
    ch_ack = ackd; cfg_we = dwe; cfg_ch = dch; cfg_div = ddiv;
    @(negedge clk);
    ch_ack = '0; cfg_we = 1'b0;
    if (b0) m_dispatch(ackd, dwe, dch, ddiv);
    else    m_idle(dwe, dch, ddiv, ackd);
  endtask

  task automatic check_model(input string name);
    chk({name, "_pend"}, 32'(ch_pending), 32'(m_pend));
    chk({name, "_ovr"},  32'(ch_overrun), 32'(m_ovr));
    chk({name, "_tick"}, 32'(tick_count), 32'(m_tick));
  endtask

  typedef struct {
    bit       cfg_we;  bit [2:0] cfg_ch;  bit [7:0] cfg_div;
    bit [3:0] ack_idle;
    bit       b0;      bit [3:0] ack_disp;
    bit       dcfg_we; bit [2:0] dcfg_ch; bit [7:0] dcfg_div;
    bit [3:0] e_pend;  bit [3:0] e_ovr;   int e_tick;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit       rwe, rb0, rdwe, done;
    logic [2:0] rch, rdch;
    logic [7:0] rdiv, rddiv;
    logic [3:0] rack, rackd;
    int       wb, prev;

    //        cfg           ack    b0 ackd  dcfg        pend     ovr      tick
    tbl[0]  = '{1,0,1,      4'h0,  1, 4'h0, 0,0,0, 4'b0001, 4'b0000, 1};
    tbl[1]  = '{1,1,3,      4'h1,  1, 4'h0, 0,0,0, 4'b0001, 4'b0000, 2};
    tbl[2]  = '{0,0,0,      4'h1,  1, 4'h0, 0,0,0, 4'b0001, 4'b0000, 3};
    tbl[3]  = '{0,0,0,      4'h1,  1, 4'h0, 0,0,0, 4'b0011, 4'b0000, 4};
    tbl[4]  = '{0,0,0,      4'h3,  1, 4'h0, 0,0,0, 4'b0001, 4'b0000, 5};
    tbl[5]  = '{0,0,0,      4'h1,  1, 4'h0, 0,0,0, 4'b0001, 4'b0000, 6};
    tbl[6]  = '{0,0,0,      4'h1,  0, 4'h0, 0,0,0, 4'b0000, 4'b0000, 6};
    tbl[7]  = '{1,2,1,      4'h0,  1, 4'h0, 0,0,0, 4'b0111, 4'b0000, 7};
    tbl[8]  = '{0,0,0,      4'h0,  1, 4'h0, 0,0,0, 4'b0111, 4'b0101, 8};
    tbl[9]  = '{0,0,0,      4'h4,  0, 4'h0, 0,0,0, 4'b0011, 4'b0001, 8};
    tbl[10] = '{0,0,0,      4'h0,  1, 4'h5, 0,0,0, 4'b0111, 4'b0000, 9};
    tbl[11] = '{1,3,2,      4'h7,  1, 4'h0, 0,0,0, 4'b0111, 4'b0000, 10};
    tbl[12] = '{0,0,0,      4'h7,  1, 4'h0, 1,3,2, 4'b0101, 4'b0000, 11};
    tbl[13] = '{0,0,0,      4'h5,  1, 4'h0, 0,0,0, 4'b0101, 4'b0000, 12};
    tbl[14] = '{0,0,0,      4'h5,  1, 4'h0, 0,0,0, 4'b1111, 4'b0000, 13};
    tbl[15] = '{1,5,1,      4'hF,  1, 4'h0, 0,0,0, 4'b0101, 4'b0000, 14};
    tbl[16] = '{1,0,0,      4'hF,  1, 4'h0, 0,0,0, 4'b1100, 4'b0000, 15};

    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_bus", {11'h0, tif.chipselect, tif.write_n, tif.address, tif.writedata},
        {11'h0, 1'b0, 1'b1, 3'd0, 16'h0000});
    chk("rst_flags", {12'h0, running, ch_pending, ch_overrun, tick_count}, 32'h0);

    reset_n = 1'b1;
    @(negedge clk);
    chk("init_write", {11'h0, tif.chipselect, tif.write_n, tif.address, tif.writedata},
        {11'h0, 1'b1, 1'b0, 3'd1, 16'h0001});
    chk("init_not_running", 32'(running), 32'd0);
    @(negedge clk);
    chk("arm_running", 32'(running), 32'd1);
    chk("arm_bus_idle", {30'h0, tif.chipselect, tif.write_n}, 32'd1);
    repeat (5) @(negedge clk);
    chk("init_single_write", 32'(ctrl_writes), 32'd1);
    chk("init_ctrl_ito", 32'(ctrl_q), 32'h0001);

    for (int i = 0; i < 17; i++) begin
      apply_idle(tbl[i].cfg_we, tbl[i].cfg_ch, tbl[i].cfg_div, tbl[i].ack_idle);
      service(tbl[i].b0, tbl[i].ack_disp, tbl[i].dcfg_we, tbl[i].dcfg_ch, tbl[i].dcfg_div);
      chk($sformatf("vec%0d_pend", i), 32'(ch_pending), 32'(tbl[i].e_pend));
      chk($sformatf("vec%0d_ovr", i),  32'(ch_overrun), 32'(tbl[i].e_ovr));
      chk($sformatf("vec%0d_tick", i), 32'(tick_count), 32'(tbl[i].e_tick));
    end

    for (int i = 0; i < 80; i++) begin
      rwe  = ($urandom_range(0, 9) < 3);
      rch  = 3'($urandom_range(0, 7));
      rdiv = 8'($urandom_range(0, 4));
      rack = 4'($urandom);
      apply_idle(rwe, rch, rdiv, rack);
      rb0   = ($urandom_range(0, 9) != 0);
      rackd = 4'($urandom);
      rdwe  = ($urandom_range(0, 9) < 2);
      rdch  = 3'($urandom_range(0, 7));
      rddiv = 8'($urandom_range(0, 3));
      service(rb0, rackd, rdwe, rdch, rddiv);
      check_model("rand");
    end

    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      prev = m_tick;
      service(1'b1, 4'hF, 1'b0, 3'd0, 8'd0);
      check_model("wrap_run");
      if (prev == (1 << TW) - 1) begin
        chk("tick_wrap_zero", 32'(tick_count), 32'd0);
        done = 1;
      end
    end
    chk("tick_wrap_reached", 32'(done), 32'd1);

    apply_idle(1'b1, 3'd0, 8'd1, 4'hF);
    service(1'b1, 4'h0, 1'b0, 3'd0, 8'd0);
    chk("pre_reset_pend0", 32'(ch_pending[0]), 32'd1);

    to_req = 1;
    @(negedge clk);
    to_req = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (tif.chipselect && tif.write_n) done = 1;
      else @(negedge clk);
    end
    chk("rst_mid_read_seen", 32'(done), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_clr", {30'h0, tif.chipselect, tif.write_n}, 32'd2);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_bus", {11'h0, tif.chipselect, tif.write_n, tif.address, tif.writedata},
        {11'h0, 1'b0, 1'b1, 3'd0, 16'h0000});
    chk("rst_mid_flags", {12'h0, running, ch_pending, ch_overrun, tick_count}, 32'h0);
    m_reset();
    @(negedge clk);
    wb = ctrl_writes;
    reset_n = 1'b1;
    @(negedge clk);
    chk("reinit_write", {11'h0, tif.chipselect, tif.write_n, tif.address, tif.writedata},
        {11'h0, 1'b1, 1'b0, 3'd1, 16'h0001});
    @(negedge clk);
    chk("reinit_running", 32'(running), 32'd1);
    repeat (3) @(negedge clk);
    chk("reinit_single_write", 32'(ctrl_writes), 32'(wb + 1));
    service(1'b1, 4'h0, 1'b0, 3'd0, 8'd0);
    check_model("post_reset");
    chk("post_reset_tick", 32'(tick_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
